// File: rtl/karatsuba_pkg.sv
// Shared definitions for the Karatsuba multiplier front end.
//   W_IN   : operand width (only 8 is supported)
//   W_NIB  : half-operand width
//   W_PROD : width of the A/B product outputs (zero-extended)
//   W_SUM  : width of the D nibble-sum output
//   state_t: sequencer states of karatsuba_factor_unit
package karatsuba_pkg;

    localparam int unsigned W_IN   = 8;
    localparam int unsigned W_NIB  = W_IN / 2;
    localparam int unsigned W_PROD = 10;
    localparam int unsigned W_SUM  = W_NIB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/karatsuba_factor_unit_nibble_shift_add_mul.sv
// One step of a 4x4 shift-add multiplier.
//   multiplicand : 4-bit operand that is shifted and added
//   multiplier   : 4-bit operand whose bit 'index' selects the add
//   index        : current bit position (0..3)
//   acc          : accumulator value before this step
//   acc_next     : accumulator value after this step
module nibble_shift_add_mul
    import karatsuba_pkg::*;
(
    input  logic [W_NIB-1:0] multiplicand,
    input  logic [W_NIB-1:0] multiplier,
    input  logic [1:0]       index,
    input  logic [W_IN-1:0]  acc,
    output logic [W_IN-1:0]  acc_next
);

    logic [W_IN-1:0] partial;

    always_comb begin
        partial = '0;
        if (multiplier[index]) begin
            partial = {{(W_IN - W_NIB){1'b0}}, multiplicand} << index;
        end
        // Largest sum is 15*15 = 225, so the 8-bit accumulator never overflows.
        acc_next = acc + partial;
    end

endmodule

// File: rtl/karatsuba_factor_unit.sv
// Sequential front end of the 8x8 Karatsuba multiplier.
// Splits X and Y into nibbles and produces A = Xl*Yl, B = Xh*Yh (4-cycle
// shift-add each) and D = Xh+Xl, with a start/done handshake.
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   start : request, sampled only in IDLE
//   X, Y  : operands, captured when start is accepted
//   A, B  : nibble products, registered, zero-extended to 10 bits
//   D     : high+low nibble sum of X, registered at acceptance
//   busy  : high while the products are being formed
//   done  : one-cycle pulse when A/B/D are valid
module karatsuba_factor_unit
    import karatsuba_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [W_IN-1:0]   X,
    input  logic [W_IN-1:0]   Y,
    output logic [W_PROD-1:0] A,
    output logic [W_PROD-1:0] B,
    output logic [W_SUM-1:0]  D,
    output logic              busy,
    output logic              done
);

    state_t          state;
    logic [W_IN-1:0] x_reg;
    logic [W_IN-1:0] y_reg;
    logic [W_IN-1:0] acc_a;
    logic [W_IN-1:0] acc_b;
    logic [W_IN-1:0] acc_a_next;
    logic [W_IN-1:0] acc_b_next;
    logic [1:0]      bit_idx;

    nibble_shift_add_mul mul_low (
        .multiplicand (x_reg[W_NIB-1:0]),
        .multiplier   (y_reg[W_NIB-1:0]),
        .index        (bit_idx),
        .acc          (acc_a),
        .acc_next     (acc_a_next)
    );

    nibble_shift_add_mul mul_high (
        .multiplicand (x_reg[W_IN-1:W_NIB]),
        .multiplier   (y_reg[W_IN-1:W_NIB]),
        .index        (bit_idx),
        .acc          (acc_b),
        .acc_next     (acc_b_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            x_reg   <= '0;
            y_reg   <= '0;
            acc_a   <= '0;
            acc_b   <= '0;
            bit_idx <= '0;
            A       <= '0;
            B       <= '0;
            D       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        x_reg   <= X;
                        y_reg   <= Y;
                        // Carry of the nibble sum lands in D[4].
                        D       <= {1'b0, X[W_IN-1:W_NIB]} + {1'b0, X[W_NIB-1:0]};
                        acc_a   <= '0;
                        acc_b   <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc_a   <= acc_a_next;
                    acc_b   <= acc_b_next;
                    bit_idx <= bit_idx + 2'd1;
                    if (bit_idx == 2'd3) begin
                        // Take the post-step value so A/B land on the final CALC edge.
                        A     <= {{(W_PROD - W_IN){1'b0}}, acc_a_next};
                        B     <= {{(W_PROD - W_IN){1'b0}}, acc_b_next};
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_factor_unit.sv
// Scoreboard bench for karatsuba_factor_unit: stimulus pushes expected
// results at acceptance; a negedge monitor pops them on done and also
// tracks busy/done timing and held output values every cycle.
module tb_karatsuba_factor_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [9:0] a_out;
    logic [9:0] b_out;
    logic [4:0] d_out;
    logic       busy;
    logic       done;

    karatsuba_factor_unit dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .X     (x_in),
        .Y     (y_in),
        .A     (a_out),
        .B     (b_out),
        .D     (d_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int a;
        int b;
        int d;
    } exp_t;

    exp_t sb[$];
    exp_t pend;

    // Reference model: phase counts cycles since acceptance (0 = idle).
    int phase = 0;
    int exp_a = 0;
    int exp_b = 0;
    int exp_d = 0;

    int checks = 0;
    int misses = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            misses++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [7:0] xv, input logic [7:0] yv);
        int xl, xh, yl, yh;
        reset = r;
        start = s;
        x_in  = xv;
        y_in  = yv;
        @(posedge clock);
        if (r) begin
            phase = 0;
            exp_a = 0;
            exp_b = 0;
            exp_d = 0;
            sb.delete();
        end else if (phase == 0) begin
            if (s) begin
                xl = int'(xv) % 16;
                xh = int'(xv) / 16;
                yl = int'(yv) % 16;
                yh = int'(yv) / 16;
                pend.x = int'(xv);
                pend.y = int'(yv);
                pend.a = xl * yl;
                pend.b = xh * yh;
                pend.d = xh + xl;
                sb.push_back(pend);
                exp_d = pend.d;
                phase = 1;
            end
        end else begin
            phase++;
            if (phase == 5) begin
                exp_a = pend.a;
                exp_b = pend.b;
            end
            if (phase == 6) phase = 0;
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        int ye, z;
        chk("busy", int'(busy), (phase >= 1 && phase <= 4) ? 1 : 0);
        chk("done", int'(done), (phase == 5) ? 1 : 0);
        chk("held_A", int'(a_out), exp_a);
        chk("held_B", int'(b_out), exp_b);
        chk("held_D", int'(d_out), exp_d);
        if (done) begin
            if (sb.size() == 0) begin
                chk("done_without_request", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("result_A", int'(a_out), e.a);
                chk("result_B", int'(b_out), e.b);
                chk("result_D", int'(d_out), e.d);
                chk("A_hi_zero", int'(a_out[9:8]), 0);
                chk("B_hi_zero", int'(b_out[9:8]), 0);
                ye = (e.y / 16) + (e.y % 16);
                z  = int'(a_out) + (int'(b_out) << 8)
                   + ((int'(d_out) * ye - int'(a_out) - int'(b_out)) << 4);
                chk("karatsuba_product", z, e.x * e.y);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x_in  = '0;
        y_in  = '0;

        // Reset then quiet idle
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        idle(10);

        // Directed operands
        step(1'b0, 1'b1, 8'h12, 8'h34);
        idle(6);
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        idle(6);
        step(1'b0, 1'b1, 8'hA5, 8'h3C);
        idle(8);
        step(1'b0, 1'b1, 8'h00, 8'h00);
        idle(6);

        // Start during CALC is ignored
        step(1'b0, 1'b1, 8'hFF, 8'hFF);
        step(1'b0, 1'b0, 8'h11, 8'h11);
        step(1'b0, 1'b1, 8'h11, 8'h11);
        idle(5);

        // Start held high: one operation every 6 cycles
        for (int i = 0; i < 18; i++) step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
        idle(6);

        // Reset on the 2nd CALC cycle aborts without done
        step(1'b0, 1'b1, 8'hA5, 8'($urandom));
        step(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        idle(6);
        step(1'b0, 1'b1, 8'h9C, 8'h7E);
        idle(6);

        // Random operations with random start noise
        for (int n = 0; n < 25; n++) begin
            step(1'b0, 1'b1, 8'($urandom), 8'($urandom));
            for (int k = 0; k < 5 + int'($urandom_range(0, 4)); k++)
                step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(8);

        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, misses);
        $finish;
    end

endmodule
